// File: rtl/req_arbiter_4.sv
// req_arbiter_4: four-requester arbiter with registered one-hot grant, tenure hold limit; define REQ_ARB_ROUND_ROBIN_EN for rotating priority.
module req_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] LIM = 8'(MAX_HOLD - 1);
  state_t state;
  logic [7:0] hold_cnt;
  logic [1:0] last_id;
  logic [1:0] win;
`ifdef REQ_ARB_ROUND_ROBIN_EN
  // i=4 wraps back to last_id itself, so the previous winner is searched last
  always_comb begin
    win = 2'd0;
    for (int i = 4; i >= 1; i--)
      if (req[last_id + 2'(i)]) win = last_id + 2'(i);
  end
`else
  logic unused_last;
  assign unused_last = ^last_id;
  always_comb begin
    win = 2'd0;
    for (int i = 0; i < 4; i++)
      if (req[i]) win = 2'(i);
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'd0;
      gnt_id   <= 2'd0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= 8'd0;
      last_id  <= 2'b11;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state    <= GRANT;
          gnt      <= 4'b0001 << win;
          gnt_id   <= win;
          gnt_vld  <= 1'b1;
          hold_cnt <= 8'd0;
          last_id  <= win;
        end
      end else if (!req[gnt_id] || (MAX_HOLD != 0 && hold_cnt == LIM)) begin
        state   <= IDLE;
        gnt     <= 4'd0;
        gnt_id  <= 2'd0;
        gnt_vld <= 1'b0;
        timeout <= req[gnt_id];
      end else begin
        hold_cnt <= hold_cnt == 8'hff ? hold_cnt : hold_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_req_arbiter_4.sv
// tb_req_arbiter_4: directed stimulus checked against a per-cycle tenure model and literal expectations.
module tb_req_arbiter_4;
  localparam int MH = 4;
  logic clk = 0, rst = 1;
  logic [3:0] req = 4'b1111;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic gnt_vld, timeout;
  int checks = 0, passes = 0;
  int owner = -1, len = 0, last = 3;
  logic tmo = 0;
`ifdef REQ_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] FIRST = 4'b0001, B_FIRST = 4'b0010;
`else
  localparam logic [3:0] FIRST = 4'b1000, B_FIRST = 4'b0100;
`endif
  req_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_id(gnt_id), .gnt_vld(gnt_vld), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic int pick(input logic [3:0] r, input int lst);
    int w = -1;
`ifdef REQ_ARB_ROUND_ROBIN_EN
    for (int k = 4; k >= 1; k--) if (r[(lst + k) % 4]) w = (lst + k) % 4;
`else
    for (int k = 0; k < 4; k++) if (r[k]) w = k;
`endif
    return w;
  endfunction
  // tenure model: owner is the granted requester (-1 none), len counts visible grant cycles
  always @(posedge clk) begin
    tmo = 0;
    if (rst) begin
      owner = -1; len = 0; last = 3;
    end else if (owner < 0) begin
      if (req != 0) begin
        owner = pick(req, last); len = 1; last = owner;
      end
    end else if (!req[owner]) begin
      owner = -1;
    end else if (MH != 0 && len == MH) begin
      owner = -1; tmo = 1;
    end else begin
      len++;
    end
  end
  always @(negedge clk) begin
    logic [8:0] exp_v;
    exp_v = owner < 0 ? {4'd0, 2'd0, 1'b0, tmo, 1'b0} : {4'b0001 << owner, 2'(owner), 1'b1, tmo, 1'b0};
    checks++;
    if ({gnt, gnt_id, gnt_vld, timeout, 1'b0} === exp_v) passes++;
    else $display("FAIL model t=%0t gnt=%b id=%0d vld=%b tmo=%b required gnt=%b id=%0d vld=%b tmo=%b",
                  $time, gnt, gnt_id, gnt_vld, timeout, exp_v[8:5], exp_v[4:3], exp_v[2], exp_v[1]);
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic lit(input string name, input logic [3:0] eg, input logic et);
    logic [1:0] eid = 2'd0;
    for (int k = 0; k < 4; k++) if (eg[k]) eid = 2'(k);
    checks++;
    if (gnt === eg && gnt_id === eid && gnt_vld === |eg && timeout === et) passes++;
    else $display("FAIL %s gnt=%b id=%0d vld=%b tmo=%b required gnt=%b id=%0d vld=%b tmo=%b",
                  name, gnt, gnt_id, gnt_vld, timeout, eg, eid, |eg, et);
  endtask
  initial begin
    step(2); lit("reset", 4'b0000, 0);
    rst = 0; step(1); lit("first_grant", FIRST, 0);
    rst = 1; req = 4'b0110; step(1); lit("reset2", 4'b0000, 0);
    rst = 0; step(1); lit("b_grant", B_FIRST, 0);
    step(1); lit("b_hold", B_FIRST, 0);
    req = 4'b0110 ^ B_FIRST; step(1); lit("b_gap", 4'b0000, 0);
    step(1); lit("b_next", 4'b0110 ^ B_FIRST, 0);
    rst = 1; step(1); req = 4'b0001; rst = 0;
    step(1); lit("c_grant", 4'b0001, 0);
    step(3); lit("c_last", 4'b0001, 0);
    step(1); lit("c_timeout", 4'b0000, 1);
    step(1); lit("c_regrant", 4'b0001, 0);
    step(4); lit("c_timeout2", 4'b0000, 1);
    step(1); lit("d_grant", 4'b0001, 0);
    req = 4'b1001; step(1); lit("d_no_preempt", 4'b0001, 0);
    req = 4'b1000; step(1); lit("d_release", 4'b0000, 0);
    step(1); lit("d_next", 4'b1000, 0);
    step(3); lit("e_hold4", 4'b1000, 0);
    req = 4'b0000; step(1); lit("e_release_wins", 4'b0000, 0);
    step(1); lit("e_idle", 4'b0000, 0);
    req = 4'b0100; step(3); lit("f_hold", 4'b0100, 0);
    rst = 1; step(1); lit("f_reset", 4'b0000, 0);
    rst = 0; req = 4'b1111; step(1); lit("f_restart", FIRST, 0);
`ifdef REQ_ARB_ROUND_ROBIN_EN
    rst = 1; step(1); rst = 0;
    for (int k = 0; k < 5; k++) begin
      step(1); lit("rr_grant", 4'b0001 << (k % 4), 0);
      step(1); lit("rr_hold", 4'b0001 << (k % 4), 0);
      req = 4'b1111 & ~(4'b0001 << (k % 4)); step(1); lit("rr_gap", 4'b0000, 0);
      req = 4'b1111;
    end
`endif
    step(1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
